// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a one-byte holding register on a
// ready/valid handshake. Bits are sampled at mid-bit, timed from the detected
// falling edge of the start bit. Framing errors and dropped bytes are reported
// as one-cycle pulses.
module uart_rx #(
  parameter int unsigned WTIME = 32'h28B0  // clock cycles per bit, >= 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       UART_RX,
  output logic [7:0] DATA,
  output logic       VALID,
  input  logic       READY,
  output logic       FRAME_ERR,
  output logic       OVERRUN,
  output logic       BUSY
);

  localparam logic [31:0] HALF_BIT = 32'(WTIME / 2);
  localparam logic [31:0] LAST_CT  = 32'(WTIME - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  // Input synchronizer and edge history
  logic       rx_meta_q;
  logic       rx_sync_q;
  logic       prev_q;
  logic       prev_d;
  logic [1:0] prime_q;
  logic [1:0] prime_d;
  logic       fall;

  // Frame FSM
  state_t      state_q;
  state_t      state_d;
  logic [31:0] ct_q;
  logic [31:0] ct_d;
  logic [2:0]  idx_q;
  logic [2:0]  idx_d;
  logic [7:0]  shift_q;
  logic [7:0]  shift_d;
  logic        commit;

  // Holding register and status pulses
  logic [7:0] data_q;
  logic [7:0] data_d;
  logic       valid_q;
  logic       valid_d;
  logic       ferr_q;
  logic       ferr_d;
  logic       ovr_q;
  logic       ovr_d;

  // The synchronizer flops reset to 1, which is not a real line level. prime_q
  // fills with ones over the two cycles it takes the pin to propagate through
  // the synchronizer; until then prev stays 0, so a line already low at reset
  // release never looks like a falling edge.
  always_comb begin
    prime_d = {prime_q[0], 1'b1};
    prev_d  = prime_q[1] ? rx_sync_q : 1'b0;
  end

  assign fall = !rx_sync_q && prev_q;

  // Two-flop synchronizer on the asynchronous serial input plus edge history
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      prev_q    <= 1'b0;
      prime_q   <= 2'b00;
    end else begin
      rx_meta_q <= UART_RX;
      rx_sync_q <= rx_meta_q;
      prev_q    <= prev_d;
      prime_q   <= prime_d;
    end
  end

  // Frame sequencing: next state, bit timing, shift register, commit decision
  always_comb begin
    state_d = state_q;
    ct_d    = ct_q + 32'd1;
    idx_d   = idx_q;
    shift_d = shift_q;
    commit  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        ct_d = '0;
        if (fall) begin
          state_d = S_START;
        end
      end
      S_START: begin
        // Mid start bit: a high line here means the edge was a glitch
        if (ct_q == HALF_BIT) begin
          ct_d    = '0;
          idx_d   = 3'd0;
          state_d = rx_sync_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (ct_q == LAST_CT) begin
          ct_d           = '0;
          shift_d[idx_q] = rx_sync_q;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (ct_q == LAST_CT) begin
          ct_d = '0;
          if (rx_sync_q) begin
            commit  = 1'b1;
            state_d = S_IDLE;
          end else begin
            // Stop bit low: report once, then wait out any break condition
            ferr_d  = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        ct_d = '0;
        if (rx_sync_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        ct_d    = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Holding register: accept a finished byte or flag it as dropped
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (commit) begin
      // A byte consumed in the same cycle frees the slot for the new one
      if (!valid_q || READY) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && READY) begin
      valid_d = 1'b0;
    end
  end

  // State, counters and output registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      ct_q    <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ct_q    <= ct_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign DATA      = data_q;
  assign VALID     = valid_q;
  assign FRAME_ERR = ferr_q;
  assign OVERRUN   = ovr_q;
  assign BUSY      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives 8N1 frames onto the serial pin and checks every cycle
// against a transaction-level model: each frame schedules a commit (or a
// framing error) at a fixed latency after its start bit hits the pin, and the
// model applies the holding-register rules at that edge.
module tb_uart_rx;

  localparam int W = 16;
  // Pin driven at a negedge -> detector sees it 2 edges later -> detection on
  // the 3rd edge; the stop sample then sits W/2 + 9W cycles later and the
  // result lands one edge after that.
  localparam int LAT = 3 + W / 2 + 9 * W + 1;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       UART_RX = 1'b1;
  logic       READY = 1'b0;
  logic [7:0] DATA;
  logic       VALID;
  logic       FRAME_ERR;
  logic       OVERRUN;
  logic       BUSY;

  uart_rx #(.WTIME(W)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .UART_RX  (UART_RX),
    .DATA     (DATA),
    .VALID    (VALID),
    .READY    (READY),
    .FRAME_ERR(FRAME_ERR),
    .OVERRUN  (OVERRUN),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;         // number of rising edges so far
  int   frame_no = 0;
  bit   chk_en = 1'b0;
  int   rdy_mode = 0;    // 0 low, 1 high, 2 random, 3 single pulse at pulse_edge
  int   pulse_edge = -1;
  int   ev[int];         // edge number -> committed byte, or -1 for framing error

  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_ferr = 1'b0;
  logic       m_ovr = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", tag, obs, exp, cyc);
    end
  endtask

  // Reference model of the consumer-visible behaviour, updated per rising edge
  always @(posedge CLK) begin : model
    int b;
    cyc    = cyc + 1;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    if (RESET) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
    end else if (ev.exists(cyc) && ev[cyc] >= 0) begin
      b = ev[cyc];
      if (!m_valid || READY) begin
        m_data  = b[7:0];
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
      ev.delete(cyc);
    end else begin
      if (ev.exists(cyc)) begin
        m_ferr = 1'b1;
        ev.delete(cyc);
      end
      if (m_valid && READY) m_valid = 1'b0;
    end
  end

  // Cycle-by-cycle comparison on the falling edge
  always @(negedge CLK) begin
    if (chk_en) begin
      check_eq("valid", VALID, m_valid);
      check_eq("data", DATA, m_data);
      check_eq("frame_err", FRAME_ERR, m_ferr);
      check_eq("overrun", OVERRUN, m_ovr);
    end
  end

  task automatic step();
    @(negedge CLK);
    case (rdy_mode)
      0:       READY = 1'b0;
      1:       READY = 1'b1;
      2:       READY = ($urandom_range(0, 2) == 0);
      default: READY = (cyc == pulse_edge - 1);
    endcase
  endtask

  task automatic idle(input int n);
    UART_RX = 1'b1;
    repeat (n) step();
  endtask

  // Leaves the line at the stop-bit level when it returns
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    logic [9:0] bits;
    bits = {stop_ok, b, 1'b0};
    ev[cyc + LAT] = stop_ok ? int'(b) : -1;
    frame_no++;
    $display("frame %0d: byte %02h stop_ok %0d commit_edge %0d", frame_no, b, stop_ok, cyc + LAT);
    for (int j = 0; j < 10; j++) begin
      UART_RX = bits[j];
      repeat (W) step();
    end
  endtask

  initial begin
    logic [7:0] rb;
    bit         rok;

    RESET = 1'b1;
    UART_RX = 1'b1;
    READY = 1'b0;
    repeat (3) step();
    check_eq("rst_valid", VALID, 1'b0);
    check_eq("rst_data", DATA, 8'h00);
    check_eq("rst_frame_err", FRAME_ERR, 1'b0);
    check_eq("rst_overrun", OVERRUN, 1'b0);
    check_eq("rst_busy", BUSY, 1'b0);
    RESET = 1'b0;
    chk_en = 1'b1;
    idle(5);

    // Single byte, consumer not ready, then a one-cycle READY pulse
    rdy_mode = 0;
    send_frame(8'h67, 1'b1);
    idle(2);
    check_eq("t1_data", DATA, 8'h67);
    check_eq("t1_valid", VALID, 1'b1);
    check_eq("t1_busy", BUSY, 1'b0);
    READY = 1'b1;
    step();
    check_eq("t1_consumed", VALID, 1'b0);

    // Back-to-back frames with READY tied high
    rdy_mode = 1;
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(5);
    check_eq("t2_data", DATA, 8'h3C);

    // Overrun: second byte dropped while the first is unconsumed
    rdy_mode = 0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(3);
    check_eq("t3_keep_data", DATA, 8'h11);
    check_eq("t3_keep_valid", VALID, 1'b1);
    rdy_mode = 1;
    idle(3);
    // Same again, but READY high exactly in the second commit cycle
    rdy_mode = 0;
    send_frame(8'h11, 1'b1);
    pulse_edge = cyc + LAT;
    rdy_mode = 3;
    send_frame(8'h22, 1'b1);
    idle(3);
    check_eq("t3_replace_data", DATA, 8'h22);
    check_eq("t3_replace_valid", VALID, 1'b1);

    // Framing error followed by a held-low line, then recovery
    rdy_mode = 1;
    idle(3);
    rdy_mode = 0;
    send_frame(8'h55, 1'b0);
    repeat (40) step();
    check_eq("t4_busy_break", BUSY, 1'b1);
    check_eq("t4_valid_break", VALID, 1'b0);
    UART_RX = 1'b1;
    repeat (5) step();
    check_eq("t4_busy_release", BUSY, 1'b0);
    send_frame(8'h5A, 1'b1);
    idle(3);
    check_eq("t4_next_data", DATA, 8'h5A);

    // Short low glitch on an idle line: false start
    rdy_mode = 1;
    idle(3);
    UART_RX = 1'b0;
    repeat (4) step();
    UART_RX = 1'b1;
    repeat (4) step();
    check_eq("t5_busy_glitch", BUSY, 1'b1);
    repeat (20) step();
    check_eq("t5_busy_after", BUSY, 1'b0);
    check_eq("t5_valid_after", VALID, 1'b0);

    // Reset during data bit 3, line held low across the release
    rdy_mode = 0;
    UART_RX = 1'b0;
    repeat (W) step();
    UART_RX = 1'b1;
    repeat (W) step();
    UART_RX = 1'b0;
    repeat (W) step();
    UART_RX = 1'b1;
    repeat (W) step();
    UART_RX = 1'b0;
    repeat (4) step();
    check_eq("t6_busy_before_rst", BUSY, 1'b1);
    chk_en = 1'b0;
    RESET = 1'b1;
    repeat (3) step();
    check_eq("t6_rst_valid", VALID, 1'b0);
    check_eq("t6_rst_data", DATA, 8'h00);
    check_eq("t6_rst_busy", BUSY, 1'b0);
    check_eq("t6_rst_frame_err", FRAME_ERR, 1'b0);
    check_eq("t6_rst_overrun", OVERRUN, 1'b0);
    RESET = 1'b0;
    chk_en = 1'b1;
    repeat (40) step();
    check_eq("t6_no_start_low", BUSY, 1'b0);
    idle(6);
    send_frame(8'hC3, 1'b1);
    idle(3);
    check_eq("t6_next_data", DATA, 8'hC3);
    check_eq("t6_next_valid", VALID, 1'b1);

    // Randomized frames, stop errors, gaps and consumer behaviour
    rdy_mode = 2;
    for (int i = 0; i < 30; i++) begin
      rb  = 8'($urandom);
      rok = ($urandom_range(0, 7) != 0);
      send_frame(rb, rok);
      if (!rok) begin
        repeat ($urandom_range(0, 30)) step();
        idle($urandom_range(4, 10));
      end else begin
        idle($urandom_range(0, 8));
      end
    end
    idle(20);
    check_eq("all_events_seen", ev.num(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: 8N1 frames on a single serial input, each byte presented to the core on a ready/valid handshake. It is the receive counterpart of the existing fixed-pattern transmitter and uses the same bit-period parameter. Default is 9600 baud at the 100 MHz board clock. It connects the physical UART RX pin to CPU-side logic, with framing-error and overrun reporting.

## Interface
- WTIME, default 32'h28B0: clock cycles per bit (100_000_000 / 9600); must be >= 4
- CLK  input  1  system clock; all logic on rising edge
- RESET  input  1  asynchronous, active-high reset
- UART_RX  input  1  serial line, idle high, asynchronous to CLK
- DATA  output  8  received byte; stable while VALID is high
- VALID  output  1  DATA holds an unconsumed byte
- READY  input  1  consumer accepts DATA on the cycle where VALID && READY
- FRAME_ERR  output  1  one-cycle pulse: stop bit sampled low
- OVERRUN  output  1  one-cycle pulse: completed byte dropped because the holding register was full
- BUSY  output  1  high in any state other than IDLE

## Operation
- **Synchronizer**: two flops on UART_RX, both reset to 1. An edge-history flop `prev` resets to 0, so a line held low through reset release is never taken as a start bit.
- **Falling edge**: synchronized rx is 0 and `prev` is 1.
- **Bit counter**: 32-bit `ct`, cleared on every state entry. Bit index: 3 bits. Shift register: 8 bits, LSB first.
- **IDLE**: on a falling edge, go to START with ct=0.
- **START**: at ct == WTIME/2 (integer division), sample rx.
  - rx=1: false start, return to IDLE with no output.
  - rx=0: go to DATA.
- **DATA**: at ct == WTIME-1, shift rx into bit[idx] and clear ct. After bit 7, go to STOP.
- **STOP**: at ct == WTIME-1, sample rx.
  - rx=1: commit the byte (see holding register), go to IDLE.
  - rx=0: pulse FRAME_ERR, discard the byte, go to WAIT_IDLE.
- **WAIT_IDLE**: stay until synchronized rx=1, then go to IDLE. A break condition (line held low) therefore produces exactly one FRAME_ERR.
- **Holding register (commit rules)**:
  - VALID=0: load DATA, set VALID=1.
  - VALID=1 and READY=1 in the commit cycle: load the new byte, VALID stays 1, no OVERRUN.
  - VALID=1 and READY=0: keep the old DATA, drop the new byte, pulse OVERRUN.
  - Otherwise, VALID && READY clears VALID on the next edge. DATA keeps its last value after consumption.
- **Reset (asserted any time, including mid-frame)**: state IDLE, ct=0, shift register 0, DATA=8'h00, VALID=0, FRAME_ERR=0, OVERRUN=0, BUSY=0, synchronizer=1, prev=0. A partial frame is lost.

## Timing
- Cycle 0 is the CLK edge on which the falling edge is detected. UART_RX reaches the detector 2 cycles after the pin changes.
- Sample points, in cycles after cycle 0:
  - start bit: WTIME/2
  - data bit k (k=0..7): WTIME/2 + (k+1)*WTIME
  - stop bit: WTIME/2 + 9*WTIME
- VALID, OVERRUN or FRAME_ERR rise on the edge after the stop sample: cycle WTIME/2 + 9*WTIME + 1.
- FRAME_ERR and OVERRUN are high for exactly one cycle.
- After a good stop, IDLE is re-entered at the stop-sample edge. A new start edge up to half a bit early is accepted.
- Back-to-back frames need no idle gap.
- Sampling at mid-bit gives about ±4.5% baud tolerance over a frame.

## Test plan
- WTIME=16; drive 8N1 'g' (8'h67) with READY=0 → VALID rises 153 cycles after the detected falling edge, DATA=8'h67, BUSY low afterwards. Then pulse READY=1 for one cycle → VALID drops on the next edge.
- WTIME=16; drive 8'hA5 then 8'h3C back-to-back, READY tied 1 → two VALID cycles with DATA 8'hA5 then 8'h3C, no OVERRUN.
- WTIME=16; READY=0, send 8'h11 then 8'h22 → DATA stays 8'h11, VALID stays 1, one OVERRUN pulse at the second commit. Repeat with READY=1 exactly on the second commit cycle → DATA=8'h22, no OVERRUN.
- WTIME=16; send 8'h55 with stop bit 0 and the line held low 40 more cycles → one FRAME_ERR pulse, VALID stays 0, BUSY high until the line returns high. A following 8'h5A is received correctly.
- WTIME=16; low glitch of 4 cycles on an idle line → returns to IDLE at the start sample, no VALID or FRAME_ERR.
- Assert RESET at data bit 3 of a frame while holding UART_RX low across the release → all outputs 0, no start detected until the line goes high and falls again. The next full frame 8'hC3 is received correctly.
